// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply datapath: feeder FSM states,
// default dimensions and an index-width helper that is safe for sizes of 1.
package matmul_pkg;

    localparam int N_DEFAULT       = 3;
    localparam int DW_DEFAULT      = 8;
    localparam int LATENCY_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    // $clog2(1) is 0, which would produce zero-width ports.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_tag_delay.sv
// LATENCY-deep shift register carrying {valid, row, col} alongside the
// dot-product pipeline; LATENCY=0 degenerates to a wire.
module matmul_tag_delay #(
    parameter int LATENCY = 2,
    parameter int W       = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] tag_in,
    output logic [W-1:0] tag_out
);

    generate
        if (LATENCY == 0) begin : g_bypass
            assign tag_out = tag_in;
        end else begin : g_pipe
            logic [W-1:0] pipe_q [LATENCY];
            logic [W-1:0] pipe_d [LATENCY];

            // Next-stage values: shift by one every cycle, bubbles included.
            always_comb begin
                pipe_d[0] = tag_in;
                for (int s = 1; s < LATENCY; s++) begin
                    pipe_d[s] = pipe_q[s-1];
                end
            end

            // Stage registers; reset flushes any in-flight tags.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int s = 0; s < LATENCY; s++) begin
                        pipe_q[s] <= '0;
                    end
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign tag_out = pipe_q[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/matmul_operand_feeder.sv
// Operand feeder: stores A and B, streams (row i of A, column j of B) pairs
// row-major into the dot-product unit and tags each result with (i,j).
// Optional FEEDER_STALL_EN adds a `stall` input that freezes issue.
module matmul_operand_feeder
    import matmul_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int DW      = DW_DEFAULT,
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_en,
    input  logic                   load_sel,
    input  logic [idx_w(N*N)-1:0]  load_addr,
    input  logic [DW-1:0]          load_data,
    input  logic                   start,
`ifdef FEEDER_STALL_EN
    input  logic                   stall,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   enable,
    output logic [N*DW-1:0]        a_vec,
    output logic [N*DW-1:0]        b_vec,
    output logic                   res_valid,
    output logic [idx_w(N)-1:0]    res_row,
    output logic [idx_w(N)-1:0]    res_col
);

    localparam int AW = idx_w(N*N);
    localparam int IW = idx_w(N);
    localparam int CW = idx_w(LATENCY + 1);
    localparam int TW = 1 + 2*IW;
    localparam logic [AW:0]   NUM_ELEM   = (AW+1)'(N*N);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N-1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

    feeder_state_t     state_q, state_d;
    logic [IW-1:0]     row_q, row_d;
    logic [IW-1:0]     col_q, col_d;
    logic [CW-1:0]     drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              enable_q, enable_d;
    logic [N*DW-1:0]   a_vec_q, a_vec_d;
    logic [N*DW-1:0]   b_vec_q, b_vec_d;
    logic [IW-1:0]     tag_row_q, tag_row_d;
    logic [IW-1:0]     tag_col_q, tag_col_d;
    logic [DW-1:0]     mem_a_q [N*N];
    logic [DW-1:0]     mem_a_d [N*N];
    logic [DW-1:0]     mem_b_q [N*N];
    logic [DW-1:0]     mem_b_d [N*N];
    logic              stall_s;
    logic [TW-1:0]     tag_out_s;

`ifdef FEEDER_STALL_EN
    assign stall_s = stall;
`else
    assign stall_s = 1'b0;
`endif

    // Next-state, counter, storage and output computation.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        drain_d   = drain_q;
        enable_d  = 1'b0;
        a_vec_d   = a_vec_q;
        b_vec_d   = b_vec_q;
        tag_row_d = tag_row_q;
        tag_col_d = tag_col_q;
        busy_d    = (state_q != IDLE);
        done_d    = (state_q == DONE);
        mem_a_d   = mem_a_q;
        mem_b_d   = mem_b_q;

        case (state_q)
            IDLE: begin
                if (load_en && ({1'b0, load_addr} < NUM_ELEM)) begin
                    if (load_sel) begin
                        mem_b_d[load_addr] = load_data;
                    end else begin
                        mem_a_d[load_addr] = load_data;
                    end
                end else begin
                    mem_a_d = mem_a_q;
                end
                if (start) begin
                    state_d = ISSUE;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (stall_s) begin
                    enable_d = 1'b0;
                end else begin
                    enable_d  = 1'b1;
                    tag_row_d = row_q;
                    tag_col_d = col_q;
                    for (int k = 0; k < N; k++) begin
                        a_vec_d[k*DW +: DW] = mem_a_q[AW'(int'(row_q) * N + k)];
                        b_vec_d[k*DW +: DW] = mem_b_q[AW'(k * N + int'(col_q))];
                    end
                    if (col_q == LAST_IDX) begin
                        col_d = '0;
                        if (row_q == LAST_IDX) begin
                            row_d   = '0;
                            drain_d = '0;
                            state_d = (LATENCY == 0) ? DONE : DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            enable_q  <= 1'b0;
            a_vec_q   <= '0;
            b_vec_q   <= '0;
            tag_row_q <= '0;
            tag_col_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            enable_q  <= enable_d;
            a_vec_q   <= a_vec_d;
            b_vec_q   <= b_vec_d;
            tag_row_q <= tag_row_d;
            tag_col_q <= tag_col_d;
        end
    end

    // Operand storage; only written while idle so a pass sees stable data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_a_q <= '{default: '0};
            mem_b_q <= '{default: '0};
        end else begin
            mem_a_q <= mem_a_d;
            mem_b_q <= mem_b_d;
        end
    end

    matmul_tag_delay #(
        .LATENCY (LATENCY),
        .W       (TW)
    ) u_tag_delay (
        .clk     (clk),
        .reset   (reset),
        .tag_in  ({enable_q, tag_row_q, tag_col_q}),
        .tag_out (tag_out_s)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign enable = enable_q;
    assign a_vec  = a_vec_q;
    assign b_vec  = b_vec_q;
    assign {res_valid, res_row, res_col} = tag_out_s;

endmodule

// File: tb/tb_matmul_operand_feeder.sv
// Directed bench for matmul_operand_feeder: per-cycle table for a full pass,
// plus sequences for load-with-start, lockout, stall and mid-pass reset.
`timescale 1ns/1ps
module tb_matmul_operand_feeder;
    import matmul_pkg::*;

    localparam int N     = 3;
    localparam int DW    = 8;
    localparam int LAT   = 2;
    localparam int AW    = idx_w(N*N);
    localparam int IW    = idx_w(N);
    localparam int TRACE = 18;

    localparam logic [N*DW-1:0] R0 = 24'h030201;
    localparam logic [N*DW-1:0] R1 = 24'h060504;
    localparam logic [N*DW-1:0] R2 = 24'h090807;
    localparam logic [N*DW-1:0] C0 = 24'h030609;
    localparam logic [N*DW-1:0] C1 = 24'h020508;
    localparam logic [N*DW-1:0] C2 = 24'h010407;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            load_en = 1'b0;
    logic            load_sel = 1'b0;
    logic [AW-1:0]   load_addr = '0;
    logic [DW-1:0]   load_data = '0;
    logic            start = 1'b0;
    logic            busy, done, enable, res_valid;
    logic [N*DW-1:0] a_vec, b_vec;
    logic [IW-1:0]   res_row, res_col;
`ifdef FEEDER_STALL_EN
    logic            stall = 1'b0;
    int              stall_lo = 100;
    int              stall_hi = -1;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int              cyc;
        logic            en;
        logic [N*DW-1:0] a;
        logic [N*DW-1:0] b;
        logic            rv;
        int              rr;
        int              rc;
        logic            bsy;
        logic            dn;
    } step_t;

    typedef struct {
        logic sel;
        int   addr;
        int   data;
    } load_t;

    step_t tbl[14];
    load_t loads[20];
    int    mat_a[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int    mat_b[9] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    int    exp_c[9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

    logic            tr_en[TRACE];
    logic [N*DW-1:0] tr_a[TRACE];
    logic [N*DW-1:0] tr_b[TRACE];
    logic            tr_rv[TRACE];
    logic [IW-1:0]   tr_rr[TRACE];
    logic [IW-1:0]   tr_rc[TRACE];
    logic            tr_busy[TRACE];
    logic            tr_done[TRACE];
    int              c_got[9];
    int              done_at, done_cnt, seq;

    always #5 clk = ~clk;

    matmul_operand_feeder #(.N(N), .DW(DW), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en),
        .load_sel  (load_sel),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
`ifdef FEEDER_STALL_EN
        .stall     (stall),
`endif
        .busy      (busy),
        .done      (done),
        .enable    (enable),
        .a_vec     (a_vec),
        .b_vec     (b_vec),
        .res_valid (res_valid),
        .res_row   (res_row),
        .res_col   (res_col)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    function automatic int dot(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
        int s = 0;
        for (int k = 0; k < N; k++) begin
            s += int'(a[k*DW +: DW]) * int'(b[k*DW +: DW]);
        end
        return s;
    endfunction

    task automatic write_elem(input logic sel, input int addr, input int data);
        load_en   = 1'b1;
        load_sel  = sel;
        load_addr = AW'(addr);
        load_data = DW'(data);
        @(posedge clk); #1;
        load_en   = 1'b0;
    endtask

    task automatic load_all();
        for (int e = 0; e < 20; e++) begin
            write_elem(loads[e].sel, loads[e].addr, loads[e].data);
        end
    endtask

    // Capture one cycle of outputs and feed the result collector.
    task automatic record(input int c);
        int idx;
        tr_en[c]   = enable;
        tr_a[c]    = a_vec;
        tr_b[c]    = b_vec;
        tr_rv[c]   = res_valid;
        tr_rr[c]   = res_row;
        tr_rc[c]   = res_col;
        tr_busy[c] = busy;
        tr_done[c] = done;
        if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
        end
        if (res_valid) begin
            idx = int'(res_row) * N + int'(res_col);
            chk("tag_order", 64'(idx), 64'(seq));
            seq++;
            if (idx < 9 && c >= LAT) c_got[idx] = dot(tr_a[c-LAT], tr_b[c-LAT]);
        end
    endtask

    task automatic run_pass(input int lock_cyc, input int st_load);
        done_at  = -1;
        done_cnt = 0;
        seq      = 0;
        for (int e = 0; e < 9; e++) c_got[e] = -1;
        if (st_load >= 0) begin
            load_en = 1'b1; load_sel = 1'b0; load_addr = '0; load_data = DW'(st_load);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; load_en = 1'b0;
        record(0);
        for (int c = 1; c < TRACE; c++) begin
`ifdef FEEDER_STALL_EN
            stall = (c >= stall_lo) && (c <= stall_hi);
`endif
            if (c == lock_cyc) begin
                start = 1'b1; load_en = 1'b1; load_sel = 1'b0; load_addr = '0; load_data = 8'd99;
            end
            @(posedge clk); #1;
            start = 1'b0; load_en = 1'b0;
`ifdef FEEDER_STALL_EN
            stall = 1'b0;
`endif
            record(c);
        end
    endtask

    task automatic check_c(input string name);
        for (int e = 0; e < 9; e++) chk(name, 64'(c_got[e]), 64'(exp_c[e]));
        chk({name, "_done_cnt"}, 64'(done_cnt), 64'(1));
    endtask

    initial begin
        tbl[0]  = '{0,  1'b0, 24'h0, 24'h0, 1'b0, 0, 0, 1'b0, 1'b0};
        tbl[1]  = '{1,  1'b1, R0, C0, 1'b0, 0, 0, 1'b1, 1'b0};
        tbl[2]  = '{2,  1'b1, R0, C1, 1'b0, 0, 0, 1'b1, 1'b0};
        tbl[3]  = '{3,  1'b1, R0, C2, 1'b1, 0, 0, 1'b1, 1'b0};
        tbl[4]  = '{4,  1'b1, R1, C0, 1'b1, 0, 1, 1'b1, 1'b0};
        tbl[5]  = '{5,  1'b1, R1, C1, 1'b1, 0, 2, 1'b1, 1'b0};
        tbl[6]  = '{6,  1'b1, R1, C2, 1'b1, 1, 0, 1'b1, 1'b0};
        tbl[7]  = '{7,  1'b1, R2, C0, 1'b1, 1, 1, 1'b1, 1'b0};
        tbl[8]  = '{8,  1'b1, R2, C1, 1'b1, 1, 2, 1'b1, 1'b0};
        tbl[9]  = '{9,  1'b1, R2, C2, 1'b1, 2, 0, 1'b1, 1'b0};
        tbl[10] = '{10, 1'b0, R2, C2, 1'b1, 2, 1, 1'b1, 1'b0};
        tbl[11] = '{11, 1'b0, R2, C2, 1'b1, 2, 2, 1'b1, 1'b0};
        tbl[12] = '{12, 1'b0, R2, C2, 1'b0, 0, 0, 1'b1, 1'b1};
        tbl[13] = '{13, 1'b0, R2, C2, 1'b0, 0, 0, 1'b0, 1'b0};
        for (int e = 0; e < 9; e++) begin
            loads[e]     = '{1'b0, e, mat_a[e]};
            loads[9 + e] = '{1'b1, e, mat_b[e]};
        end
        loads[18] = '{1'b0, 9, 77};
        loads[19] = '{1'b1, 15, 77};

        // Reset held with random inputs: every output must stay zero.
        for (int r = 0; r < 4; r++) begin
            load_en   = 1'($urandom_range(0, 1));
            load_sel  = 1'($urandom_range(0, 1));
            load_addr = AW'($urandom_range(0, 15));
            load_data = DW'($urandom_range(0, 255));
            start     = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("reset_outputs", 64'({busy, done, enable, res_valid, res_row, res_col, a_vec, b_vec}), 64'(0));
        end
        load_en = 1'b0; start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_reset", 64'(busy), 64'(0));

        // Full pass, compared cycle by cycle.
        load_all();
        run_pass(-1, -1);
        for (int s = 0; s < 14; s++) begin
            chk("enable", 64'(tr_en[tbl[s].cyc]), 64'(tbl[s].en));
            chk("a_vec", 64'(tr_a[tbl[s].cyc]), 64'(tbl[s].a));
            chk("b_vec", 64'(tr_b[tbl[s].cyc]), 64'(tbl[s].b));
            chk("res_valid", 64'(tr_rv[tbl[s].cyc]), 64'(tbl[s].rv));
            chk("busy", 64'(tr_busy[tbl[s].cyc]), 64'(tbl[s].bsy));
            chk("done", 64'(tr_done[tbl[s].cyc]), 64'(tbl[s].dn));
            if (tbl[s].rv) begin
                chk("res_row", 64'(tr_rr[tbl[s].cyc]), 64'(tbl[s].rr));
                chk("res_col", 64'(tr_rc[tbl[s].cyc]), 64'(tbl[s].rc));
            end
        end
        chk("dot_cycle1", 64'(dot(tr_a[1], tr_b[1])), 64'(30));
        check_c("c_full");

        // Load together with start lands before the first issue.
        run_pass(-1, 2);
        chk("st_load_a_vec", 64'(tr_a[1]), 64'(24'h030202));
        chk("st_load_c00", 64'(c_got[0]), 64'(39));
        chk("st_load_done_at", 64'(done_at), 64'(12));
        write_elem(1'b0, 0, 1);

        // Start and load during ISSUE are ignored.
        run_pass(3, -1);
        chk("lock_done_at", 64'(done_at), 64'(12));
        check_c("c_lock");
        run_pass(-1, -1);
        chk("lock_a0_kept", 64'(tr_a[1]), 64'(R0));
        check_c("c_after_lock");

`ifdef FEEDER_STALL_EN
        stall_lo = 4; stall_hi = 5;
        run_pass(-1, -1);
        stall_lo = 100; stall_hi = -1;
        chk("stall_en4", 64'(tr_en[4]), 64'(0));
        chk("stall_en5", 64'(tr_en[5]), 64'(0));
        chk("stall_en6", 64'(tr_en[6]), 64'(1));
        chk("stall_a6", 64'(tr_a[6]), 64'(R1));
        chk("stall_b6", 64'(tr_b[6]), 64'(C0));
        chk("stall_done_at", 64'(done_at), 64'(14));
        check_c("c_stall");
`endif

        // Reset asserted in cycle 5 aborts the pass immediately.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midpass_running", 64'({enable, busy}), 64'(2'b11));
        reset = 1'b0;
        #1;
        chk("midpass_enable", 64'(enable), 64'(0));
        chk("midpass_res_valid", 64'(res_valid), 64'(0));
        chk("midpass_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (done || busy || res_valid) done_cnt++;
        end
        chk("midpass_quiet", 64'(done_cnt), 64'(0));
        load_all();
        run_pass(-1, -1);
        chk("rerun_done_at", 64'(done_at), 64'(12));
        check_c("c_rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
